// File: rtl/regfile_writer_if.sv
// regfile_writer_if: write-request handshake between the write-back stage and
// regfile_writer.
//   req_valid  master->slave  request present
//   req_ready  slave->master  request can be accepted this cycle
//   req_reg    master->slave  destination register number (2 bits)
//   req_data   master->slave  write data (DATA_W bits)
interface regfile_writer_if #(
    parameter int unsigned DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_reg;
    logic [DATA_W-1:0] req_data;

    modport master (
        output req_valid,
        output req_reg,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_reg,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_writer.sv
// regfile_writer: write-side front end for a 4-entry, DATA_W-bit register file.
// Write requests are accepted over a valid/ready handshake, buffered in an
// in-order queue of DEPTH entries and issued one per cycle through a single
// issue-stage register that drives the register file write port.
//
// Optional feature macro: REGFILE_WRITER_FWD_EN
//   defined     -> rd1/rd2 return the youngest pending write to the selected
//                  register (register 0 reads as zero)
//   not defined -> rd1/rd2 pass rf_rd1/rf_rd2 straight through
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   req                 request handshake (regfile_writer_if.slave)
//   stall               register file must not be written this cycle
//   rf_wr, rf_wd        register file write select / data (issue stage)
//   rf_regwrite         register file write enable
//   rd_sel1, rd_sel2    read selects (also seen by the register file)
//   rf_rd1, rf_rd2      raw register file read data
//   rd1, rd2            forwarded read data
//   busy                any write pending (queued or in issue stage)
module regfile_writer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    regfile_writer_if.slave   req,
    input  logic              stall,
    output logic [1:0]        rf_wr,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_regwrite,
    input  logic [1:0]        rd_sel1,
    input  logic [1:0]        rd_sel2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [1:0]        rnum;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Issue-stage occupancy; LOADED is the out_valid of the issue register.
    typedef enum logic {
        EMPTY  = 1'b0,
        LOADED = 1'b1
    } state_t;

    state_t           state;
    entry_t           out_q;
    entry_t           q [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic   accept;
    logic   keep;
    logic   have_q;
    logic   push_q;
    logic   pop;
    logic   bypass;
    entry_t entry_in;

    // Handshake and queue control decode.
    always_comb begin
        accept   = req.req_valid & req.req_ready;
        keep     = accept & (req.req_reg != 2'd0);
        have_q   = (count != '0);
        pop      = ~stall & have_q;
        // A kept request joins the queue unless it can go straight to issue.
        push_q   = keep & (stall | have_q);
        bypass   = keep & ~stall & ~have_q;
        entry_in = '{rnum: req.req_reg, data: req.req_data};
    end

    assign req.req_ready = (count < CNT_W'(DEPTH)) & ~reset;

    // Issue stage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
            out_q <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (!stall) begin
                if (pop) begin
                    state <= LOADED;
                    out_q <= q[head];
                    head  <= head + PTR_W'(1);
                end else if (bypass) begin
                    state <= LOADED;
                    out_q <= entry_in;
                end else begin
                    state <= EMPTY;
                end
            end

            if (push_q) begin
                tail <= tail + PTR_W'(1);
            end

            case ({push_q, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clock) begin
        if (push_q) begin
            q[tail] <= entry_in;
        end
    end

    assign rf_wr       = out_q.rnum;
    assign rf_wd       = out_q.data;
    assign rf_regwrite = (state == LOADED) & ~stall;
    assign busy        = (state == LOADED) | have_q;

`ifdef REGFILE_WRITER_FWD_EN
    // Youngest pending write wins: scan issue stage first, then queue head to
    // tail so later matches overwrite earlier ones.
    function automatic logic [DATA_W-1:0] fwd(input logic [1:0]        sel,
                                              input logic [DATA_W-1:0] raw);
        logic [DATA_W-1:0] val;
        logic [PTR_W-1:0]  idx;
        val = raw;
        if ((state == LOADED) && (out_q.rnum == sel)) begin
            val = out_q.data;
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (q[idx].rnum == sel)) begin
                val = q[idx].data;
            end
        end
        if (sel == 2'd0) begin
            val = '0;
        end
        return val;
    endfunction

    always_comb begin
        rd1 = fwd(rd_sel1, rf_rd1);
        rd2 = fwd(rd_sel2, rf_rd2);
    end
`else
    // Without forwarding the read selects only go to the register file.
    logic unused_sel;
    assign unused_sel = ^{rd_sel1, rd_sel2};

    assign rd1 = rf_rd1;
    assign rd2 = rf_rd2;
`endif

endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: directed vector table for the documented scenarios, then
// randomized traffic compared against a queue-level reference model.
module tb_regfile_writer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 2;
    localparam int          NRAND  = 2000;

    logic              clock = 1'b0;
    logic              reset;
    logic              stall;
    logic [1:0]        rd_sel1, rd_sel2;
    logic [DATA_W-1:0] rf_rd1, rf_rd2;
    logic [1:0]        rf_wr;
    logic [DATA_W-1:0] rf_wd;
    logic              rf_regwrite;
    logic [DATA_W-1:0] rd1, rd2;
    logic              busy;

    always #5 clock = ~clock;

    regfile_writer_if #(.DATA_W(DATA_W)) rif ();

    regfile_writer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (rif),
        .stall       (stall),
        .rf_wr       (rf_wr),
        .rf_wd       (rf_wd),
        .rf_regwrite (rf_regwrite),
        .rd_sel1     (rd_sel1),
        .rd_sel2     (rd_sel2),
        .rf_rd1      (rf_rd1),
        .rf_rd2      (rf_rd2),
        .rd1         (rd1),
        .rd2         (rd2),
        .busy        (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        rst, vld;
        logic [1:0]  r;
        logic [15:0] d;
        logic        stl;
        logic [1:0]  s1;
        logic [15:0] rf1;
        logic        e_rdy, e_we, chkw;
        logic [1:0]  e_wr;
        logic [15:0] e_wd;
        logic        e_busy;
        logic [15:0] e_rd1f, e_rd1r;
    } vec_t;

    function automatic vec_t mk(
        input logic rst, input logic vld, input logic [1:0] r, input logic [15:0] d,
        input logic stl, input logic [1:0] s1, input logic [15:0] rf1,
        input logic e_rdy, input logic e_we, input logic chkw, input logic [1:0] e_wr,
        input logic [15:0] e_wd, input logic e_busy,
        input logic [15:0] e_rd1f, input logic [15:0] e_rd1r);
        vec_t v;
        v.rst = rst; v.vld = vld; v.r = r; v.d = d; v.stl = stl; v.s1 = s1; v.rf1 = rf1;
        v.e_rdy = e_rdy; v.e_we = e_we; v.chkw = chkw; v.e_wr = e_wr; v.e_wd = e_wd;
        v.e_busy = e_busy; v.e_rd1f = e_rd1f; v.e_rd1r = e_rd1r;
        return v;
    endfunction

    vec_t tbl[$];

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t mq[$];
    bit   mv;
    ent_t mi;

`ifdef REGFILE_WRITER_FWD_EN
    function automatic logic [15:0] m_fwd(input logic [1:0] sel, input logic [15:0] raw);
        if (sel == 2'd0) return 16'h0000;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].r == sel) return mq[i].d;
        if (mv && mi.r == sel) return mi.d;
        return raw;
    endfunction
`endif

    // Advance the model across one rising edge using the current inputs.
    task automatic m_edge();
        bit   acc, keep;
        ent_t e;
        if (reset) begin
            mq.delete();
            mv = 1'b0;
        end else begin
            acc  = rif.req_valid && (mq.size() < int'(DEPTH));
            keep = acc && (rif.req_reg != 2'd0);
            e    = '{r: rif.req_reg, d: rif.req_data};
            if (!stall) begin
                if (mq.size() > 0) begin
                    mi = mq.pop_front();
                    mv = 1'b1;
                    if (keep) mq.push_back(e);
                end else if (keep) begin
                    mi = e;
                    mv = 1'b1;
                end else begin
                    mv = 1'b0;
                end
            end else if (keep) begin
                mq.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [15:0] exp1, exp2;
        logic        exp_we;

        // rst vld r  d        stl s1 rf1      | rdy we chkw wr wd       busy rd1f     rd1r
        tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h1234, 0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 1, 1, 16'hA5A5, 0, 0, 16'h1234, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'h0000, 1, 1, 1, 1, 16'hA5A5, 1, 16'hA5A5, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 1, 16'hA5A5, 1, 0, 0, 0, 16'h0000, 0, 16'hA5A5, 16'hA5A5));
        // fill and drain
        tbl.push_back(mk(0, 1, 1, 16'h0001, 0, 0, 16'h1234, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 1, 2, 16'h0002, 1, 0, 16'h1234, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 1, 3, 16'h0003, 1, 0, 16'h1234, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 1, 2, 16'h00EE, 1, 2, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 16'h0002, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h1234, 0, 1, 1, 1, 16'h0001, 1, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h1234, 1, 1, 1, 2, 16'h0002, 1, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 3, 16'h0000, 1, 1, 1, 3, 16'h0003, 1, 16'h0003, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 3, 16'h0003, 1, 0, 0, 0, 16'h0000, 0, 16'h0003, 16'h0003));
        // register 0
        tbl.push_back(mk(0, 1, 0, 16'hFFFF, 0, 0, 16'h1234, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h1234, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h1234));
        // forwarding priority
        tbl.push_back(mk(0, 1, 2, 16'h0011, 1, 2, 16'h0000, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 1, 2, 16'h0022, 1, 2, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 16'h0011, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 2, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 16'h0022, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 2, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 16'h0022, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 2, 16'h0000, 1, 1, 1, 2, 16'h0011, 1, 16'h0022, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 2, 16'h0011, 1, 1, 1, 2, 16'h0022, 1, 16'h0022, 16'h0011));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 2, 16'h0022, 1, 0, 0, 0, 16'h0000, 0, 16'h0022, 16'h0022));
        // reset mid-operation
        tbl.push_back(mk(0, 1, 1, 16'h0AAA, 0, 0, 16'h1234, 1, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 1, 2, 16'h0BBB, 1, 0, 16'h1234, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h1234));
        tbl.push_back(mk(0, 1, 3, 16'h0CCC, 1, 0, 16'h1234, 1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'h1234));
        tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 2, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 16'h0BBB, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 2, 16'h0000, 1, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000));
        tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h1234, 1, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h1234));

        // Two reset cycles before the table starts.
        reset = 1'b1; stall = 1'b0;
        rif.req_valid = 1'b0; rif.req_reg = 2'd0; rif.req_data = '0;
        rd_sel1 = 2'd0; rd_sel2 = 2'd0; rf_rd1 = '0; rf_rd2 = '0;
        tick();
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            reset         = tbl[i].rst;
            rif.req_valid = tbl[i].vld;
            rif.req_reg   = tbl[i].r;
            rif.req_data  = tbl[i].d;
            stall         = tbl[i].stl;
            rd_sel1       = tbl[i].s1;
            rf_rd1        = tbl[i].rf1;
            rd_sel2       = 2'd0;
            rf_rd2        = '0;
            #2;
            chk($sformatf("vec%0d ready", i), 32'(rif.req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d regwrite", i), 32'(rf_regwrite), 32'(tbl[i].e_we));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            if (tbl[i].chkw) begin
                chk($sformatf("vec%0d wr", i), 32'(rf_wr), 32'(tbl[i].e_wr));
                chk($sformatf("vec%0d wd", i), 32'(rf_wd), 32'(tbl[i].e_wd));
            end
`ifdef REGFILE_WRITER_FWD_EN
            chk($sformatf("vec%0d rd1", i), 32'(rd1), 32'(tbl[i].e_rd1f));
`else
            chk($sformatf("vec%0d rd1", i), 32'(rd1), 32'(tbl[i].e_rd1r));
`endif
            tick();
        end

        // Randomized traffic against the model, starting from a clean reset.
        reset = 1'b1; rif.req_valid = 1'b0; stall = 1'b0;
        m_edge();
        tick();

        for (int n = 0; n < NRAND; n++) begin
            reset         = ($urandom_range(63) == 0);
            rif.req_valid = ($urandom_range(3) != 0);
            rif.req_reg   = 2'($urandom_range(3));
            rif.req_data  = 16'($urandom);
            stall         = ($urandom_range(2) == 0);
            rd_sel1       = 2'($urandom_range(3));
            rd_sel2       = 2'($urandom_range(3));
            rf_rd1        = 16'($urandom);
            rf_rd2        = 16'($urandom);
            #2;
            exp_we = mv && !stall;
`ifdef REGFILE_WRITER_FWD_EN
            exp1 = m_fwd(rd_sel1, rf_rd1);
            exp2 = m_fwd(rd_sel2, rf_rd2);
`else
            exp1 = rf_rd1;
            exp2 = rf_rd2;
`endif
            chk("rnd ready", 32'(rif.req_ready), 32'((mq.size() < int'(DEPTH)) && !reset));
            chk("rnd regwrite", 32'(rf_regwrite), 32'(exp_we));
            chk("rnd busy", 32'(busy), 32'(mv || (mq.size() != 0)));
            if (exp_we) begin
                chk("rnd wr", 32'(rf_wr), 32'(mi.r));
                chk("rnd wd", 32'(rf_wd), 32'(mi.d));
            end
            chk("rnd rd1", 32'(rd1), 32'(exp1));
            chk("rnd rd2", 32'(rd2), 32'(exp2));
            m_edge();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
